// File: rtl/tdm_demux.sv
// TDM slot demultiplexer: HUNT/LOCK frame alignment, one-cycle latency to per-channel fields.
// Define TDM_DEMUX_FRAME_BUF_EN for atomic whole-frame delivery through a shadow buffer.
module tdm_demux #(
  parameter int NCH = 4,
  parameter int W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic             in_sof,
  output logic [NCH*W-1:0] out_data,
  output logic [NCH-1:0]   out_ch_valid,
  output logic             frame_done,
  output logic             sync_err,
  output logic             locked
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic          take;
  logic          bad;
  logic          drop;
  logic          is_last;
  logic [CW-1:0] slot;

  // Handshake: in_valid alone qualifies in_data/in_sof; there is no backpressure,
  // so every valid word is consumed (routed or discarded) in the cycle it is presented.
  always_comb begin
    take = 1'b0;
    bad  = 1'b0;
    drop = 1'b0;
    slot = '0;
    if (in_valid) begin
      if (in_sof) begin
        take = 1'b1;
        bad  = (state == LOCK) && (cnt != '0);
      end else if (state == LOCK) begin
        if (cnt == '0) begin
          bad  = 1'b1;
          drop = 1'b1;
        end else begin
          take = 1'b1;
          slot = cnt;
        end
      end
    end
    is_last = take && (slot == LAST);
  end

  assign locked = (state == LOCK);

`ifdef TDM_DEMUX_FRAME_BUF_EN
  // Slots 0..NCH-2 wait here; the last slot word is merged straight into out_data.
  logic [(NCH-1)*W-1:0] shadow;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HUNT;
      cnt          <= '0;
      out_data     <= '0;
      out_ch_valid <= '0;
      frame_done   <= 1'b0;
      sync_err     <= 1'b0;
`ifdef TDM_DEMUX_FRAME_BUF_EN
      shadow       <= '0;
`endif
    end else begin
      out_ch_valid <= '0;
      frame_done   <= is_last;
      sync_err     <= bad;
      if (take) begin
        state <= LOCK;
        cnt   <= is_last ? '0 : slot + CW'(1);
`ifdef TDM_DEMUX_FRAME_BUF_EN
        if (is_last) begin
          out_data     <= {in_data, shadow};
          out_ch_valid <= '1;
        end else begin
          shadow[int'(slot)*W +: W] <= in_data;
        end
`else
        out_data[int'(slot)*W +: W] <= in_data;
        out_ch_valid                <= NCH'(1) << slot;
`endif
      end else if (drop) begin
        state <= HUNT;
        cnt   <= '0;
      end
    end
  end

endmodule
